slave_tx_serializer: RTL and testbench

Parametrised slave-side serial transmit port for the system bus: accepts parallel words from the slave core through a valid/ready handshake and shifts them out one bit per clock toward the master. Generalises the 8-bit slave output port with configurable word width, bit order, an optional start-bit frame delimiter, and a one-entry holding buffer that allows back-to-back frames with no idle gap. Sits between the slave core's read-data path and the bus serial return line.

---
 rtl/slave_tx_serializer.sv | 140 ++++++++++++++
 tb/tb_slave_tx_serializer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/slave_tx_serializer.sv
// Slave-side serial transmit port: a one-word holding buffer fed by a valid/ready
// handshake, and a shift engine that sends each word as a frame, one bit per clock
// and optionally preceded by a start bit.
module slave_tx_serializer #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned MSB_FIRST  = 0,
   parameter int unsigned START_BIT  = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  slave_valid,
   output logic                  slave_ready,
   input  logic                  master_ready,
   output logic                  tx_data,
   output logic                  tx_valid,
   output logic                  tx_done,
   output logic                  busy
);

   localparam int unsigned CntW = $clog2(DATA_WIDTH);
   localparam logic [CntW-1:0] LastIdx = CntW'(DATA_WIDTH - 1);

   typedef enum logic [1:0] {StIdle, StStart, StShift} state_e;

   state_e                state_q, state_d;
   logic [DATA_WIDTH-1:0] hold_q, hold_d;
   logic                  hold_full_q, hold_full_d;
   logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
   logic [CntW-1:0]       cnt_q, cnt_d;
   logic                  tx_data_q, tx_data_d;
   logic                  tx_valid_q, tx_valid_d;
   logic                  tx_done_q, tx_done_d;
   logic                  load;

   // Bit that leaves the word first in the configured order.
   function automatic logic first_bit(logic [DATA_WIDTH-1:0] w);
      return (MSB_FIRST != 0) ? w[DATA_WIDTH-1] : w[0];
   endfunction

   // Drop the bit just sent so the next one sits at the output end.
   function automatic logic [DATA_WIDTH-1:0] shift_out(logic [DATA_WIDTH-1:0] w);
      return (MSB_FIRST != 0) ? {w[DATA_WIDTH-2:0], 1'b0} : {1'b0, w[DATA_WIDTH-1:1]};
   endfunction

   assign slave_ready = !hold_full_q && !reset;
   assign busy        = hold_full_q || (state_q != StIdle);
   assign tx_data     = tx_data_q;
   assign tx_valid    = tx_valid_q;
   assign tx_done     = tx_done_q;

   // Next-state, buffer and registered-output logic; cnt is the index of the data bit on the line.
   always_comb begin
      state_d     = state_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      shreg_d     = shreg_q;
      cnt_d       = cnt_q;
      tx_data_d   = 1'b0;
      tx_valid_d  = 1'b0;
      tx_done_d   = 1'b0;
      load        = 1'b0;

      // Accept and load are exclusive: accept needs an empty buffer, load a full one.
      if (slave_valid && slave_ready) begin
         hold_d      = data_in;
         hold_full_d = 1'b1;
      end

      unique case (state_q)
         StIdle: begin
            load = hold_full_q && master_ready;
         end
         StStart: begin
            state_d    = StShift;
            tx_valid_d = 1'b1;
            tx_data_d  = first_bit(shreg_q);
            shreg_d    = shift_out(shreg_q);
            cnt_d      = '0;
         end
         StShift: begin
            if (cnt_q == LastIdx) begin
               load = hold_full_q && master_ready;
               if (!load) begin
                  state_d = StIdle;
               end
            end else begin
               tx_valid_d = 1'b1;
               tx_data_d  = first_bit(shreg_q);
               shreg_d    = shift_out(shreg_q);
               cnt_d      = cnt_q + CntW'(1);
               tx_done_d  = (cnt_q + CntW'(1)) == LastIdx;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // Frame start: the first frame bit is registered on this same edge.
      if (load) begin
         hold_full_d = 1'b0;
         cnt_d       = '0;
         tx_valid_d  = 1'b1;
         if (START_BIT != 0) begin
            state_d   = StStart;
            tx_data_d = 1'b1;
            shreg_d   = hold_q;
         end else begin
            state_d   = StShift;
            tx_data_d = first_bit(hold_q);
            shreg_d   = shift_out(hold_q);
         end
      end
   end

   // State register with synchronous reset; a pending word is discarded on reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         shreg_q     <= '0;
         cnt_q       <= '0;
         tx_data_q   <= 1'b0;
         tx_valid_q  <= 1'b0;
         tx_done_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         shreg_q     <= shreg_d;
         cnt_q       <= cnt_d;
         tx_data_q   <= tx_data_d;
         tx_valid_q  <= tx_valid_d;
         tx_done_q   <= tx_done_d;
      end
   end

endmodule

// File: tb/tb_slave_tx_serializer.sv
// Bench for slave_tx_serializer: two instances (8-bit LSB-first with start bit, and
// 16-bit MSB-first without) checked every cycle against a frame/position model.
module tb_slave_tx_serializer;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  d0;
   logic [15:0] d1;
   logic        sv0, sv1, mr0, mr1;
   logic        sr0, sr1, txd0, txd1, txv0, txv1, txdn0, txdn1, bz0, bz1;

   int total = 0;
   int bad   = 0;

   // Model configuration and state, indexed by instance.
   int          cw[2] = '{8, 16};
   int          cm[2] = '{0, 1};
   int          cs[2] = '{1, 0};
   logic        m_hf[2];
   logic [63:0] m_hw[2];
   logic        m_act[2];
   int          m_pos[2];
   logic [63:0] m_fw[2];

   // Capture of the transmitted stream (first bit ends up most significant).
   logic        cap_en[2];
   logic [63:0] cap_m[2];
   logic [63:0] cap_d[2];
   logic [63:0] cap_dn[2];
   int          cap_n[2];

   always #5 clk = ~clk;

   slave_tx_serializer u0 (
      .clk(clk), .reset(reset), .data_in(d0), .slave_valid(sv0), .slave_ready(sr0),
      .master_ready(mr0), .tx_data(txd0), .tx_valid(txv0), .tx_done(txdn0), .busy(bz0)
   );

   slave_tx_serializer #(.DATA_WIDTH(16), .MSB_FIRST(1), .START_BIT(0)) u1 (
      .clk(clk), .reset(reset), .data_in(d1), .slave_valid(sv1), .slave_ready(sr1),
      .master_ready(mr1), .tx_data(txd1), .tx_valid(txv1), .tx_done(txdn1), .busy(bz1)
   );

   function automatic int frame_len(int i);
      return cw[i] + cs[i];
   endfunction

   // Bit on the line for the current frame position.
   function automatic logic exp_data(int i);
      int idx;
      if (!m_act[i]) return 1'b0;
      if (cs[i] != 0 && m_pos[i] == 0) return 1'b1;
      idx = m_pos[i] - cs[i];
      if (cm[i] != 0) idx = cw[i] - 1 - idx;
      return m_fw[i][idx];
   endfunction

   // Advance the model across one rising edge using the inputs present before it.
   task automatic model_edge(int i, logic v, logic [63:0] d, logic mr);
      logic last, ld, acc;
      if (reset) begin
         m_hf[i]  = 1'b0;
         m_act[i] = 1'b0;
         m_pos[i] = 0;
         return;
      end
      last = m_act[i] && (m_pos[i] == frame_len(i) - 1);
      ld   = m_hf[i] && mr && (!m_act[i] || last);
      acc  = v && !m_hf[i];
      if (m_act[i] && !last) begin
         m_pos[i]++;
      end else if (ld) begin
         m_act[i] = 1'b1;
         m_pos[i] = 0;
         m_fw[i]  = m_hw[i];
         m_hf[i]  = 1'b0;
      end else begin
         m_act[i] = 1'b0;
      end
      if (acc) begin
         m_hf[i] = 1'b1;
         m_hw[i] = d;
      end
   endtask

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check(int i);
      logic ev, ed, edn, eb, er;
      logic av, ad, adn, ab, ar;
      ev  = m_act[i];
      ed  = exp_data(i);
      edn = m_act[i] && (m_pos[i] == frame_len(i) - 1);
      eb  = m_hf[i] || m_act[i];
      er  = !m_hf[i] && !reset;
      if (i == 0) begin
         av = txv0; ad = txd0; adn = txdn0; ab = bz0; ar = sr0;
      end else begin
         av = txv1; ad = txd1; adn = txdn1; ab = bz1; ar = sr1;
      end
      chk($sformatf("u%0d tx_valid t=%0t", i, $time), 64'(av), 64'(ev));
      chk($sformatf("u%0d tx_data t=%0t", i, $time), 64'(ad), 64'(ed));
      chk($sformatf("u%0d tx_done t=%0t", i, $time), 64'(adn), 64'(edn));
      chk($sformatf("u%0d busy t=%0t", i, $time), 64'(ab), 64'(eb));
      chk($sformatf("u%0d slave_ready t=%0t", i, $time), 64'(ar), 64'(er));
      if (cap_en[i] && ev) begin
         cap_m[i]  = {cap_m[i][62:0], ed};
         cap_d[i]  = {cap_d[i][62:0], ad};
         cap_dn[i] = {cap_dn[i][62:0], adn};
         cap_n[i]++;
      end
   endtask

   task automatic start_cap(int i);
      cap_en[i] = 1'b1;
      cap_m[i]  = '0;
      cap_d[i]  = '0;
      cap_dn[i] = '0;
      cap_n[i]  = 0;
   endtask

   task automatic step();
      model_edge(0, sv0, 64'(d0), mr0);
      model_edge(1, sv1, 64'(d1), mr1);
      @(posedge clk);
      #1;
      check(0);
      check(1);
   endtask

   task automatic steps(int n);
      for (int k = 0; k < n; k++) step();
   endtask

   initial begin
      reset = 1'b1;
      sv0 = 1'b0; sv1 = 1'b0; mr0 = 1'b1; mr1 = 1'b1; d0 = '0; d1 = '0;
      for (int i = 0; i < 2; i++) begin
         m_hf[i] = 1'b0; m_hw[i] = '0; m_act[i] = 1'b0; m_pos[i] = 0; m_fw[i] = '0;
         cap_en[i] = 1'b0; cap_m[i] = '0; cap_d[i] = '0; cap_dn[i] = '0; cap_n[i] = 0;
      end
      @(negedge clk);

      // Reset held for two cycles, then released.
      steps(2);
      chk("reset tx_valid", 64'(txv0), 64'(0));
      chk("reset slave_ready", 64'(sr0), 64'(0));
      reset = 1'b0;
      step();
      chk("post-reset slave_ready", 64'(sr0), 64'(1));
      chk("post-reset busy", 64'(bz0), 64'(0));

      // Single frames on both instances.
      start_cap(0); start_cap(1);
      sv0 = 1'b1; d0 = 8'hA5; sv1 = 1'b1; d1 = 16'h3C81;
      step();
      sv0 = 1'b0; sv1 = 1'b0; d0 = 8'h00; d1 = 16'hFFFF;
      steps(20);
      chk("a5 model stream", cap_m[0], 64'b110100101);
      chk("a5 dut stream", cap_d[0], 64'b110100101);
      chk("a5 done", cap_dn[0], 64'b000000001);
      chk("a5 length", 64'(cap_n[0]), 64'd9);
      chk("3c81 model stream", cap_m[1], 64'h3C81);
      chk("3c81 dut stream", cap_d[1], 64'h3C81);
      chk("3c81 done", cap_dn[1], 64'h0001);
      chk("3c81 length", 64'(cap_n[1]), 64'd16);

      // Back-to-back: second word accepted while the first frame is on the line.
      start_cap(0);
      sv0 = 1'b1; d0 = 8'h01;
      step();
      sv0 = 1'b0;
      steps(3);
      sv0 = 1'b1; d0 = 8'h80;
      step();
      sv0 = 1'b0;
      steps(20);
      chk("b2b model stream", cap_m[0], 64'b110000000100000001);
      chk("b2b dut stream", cap_d[0], 64'b110000000100000001);
      chk("b2b done", cap_dn[0], 64'b000000001000000001);
      chk("b2b length", 64'(cap_n[0]), 64'd18);

      // Held by master_ready=0; a second offered word must be refused.
      mr0 = 1'b0;
      sv0 = 1'b1; d0 = 8'h55;
      step();
      d0 = 8'h33;
      steps(5);
      chk("hold busy", 64'(bz0), 64'(1));
      chk("hold slave_ready", 64'(sr0), 64'(0));
      chk("hold tx_valid", 64'(txv0), 64'(0));
      sv0 = 1'b0;
      start_cap(0);
      mr0 = 1'b1;
      step();
      chk("hold start bit valid", 64'(txv0), 64'(1));
      steps(12);
      chk("hold dut stream", cap_d[0], 64'b110101010);
      chk("hold length", 64'(cap_n[0]), 64'd9);

      // Reset after the third data bit of 0xFF, then a clean 0x0F frame.
      start_cap(0);
      sv0 = 1'b1; d0 = 8'hFF;
      step();
      sv0 = 1'b0;
      steps(4);
      reset = 1'b1;
      step();
      chk("mid reset tx_valid", 64'(txv0), 64'(0));
      reset = 1'b0;
      steps(3);
      chk("mid reset no done", cap_dn[0], 64'(0));
      start_cap(0);
      sv0 = 1'b1; d0 = 8'h0F;
      step();
      sv0 = 1'b0;
      steps(12);
      chk("0f dut stream", cap_d[0], 64'b111110000);
      chk("0f done", cap_dn[0], 64'b000000001);
      cap_en[0] = 1'b0; cap_en[1] = 1'b0;

      // Randomized traffic with occasional master stalls and resets.
      for (int c = 0; c < 3000; c++) begin
         sv0   = ($urandom_range(0, 3) == 0);
         sv1   = ($urandom_range(0, 4) == 0);
         d0    = 8'($urandom);
         d1    = 16'($urandom);
         mr0   = ($urandom_range(0, 7) != 0);
         mr1   = ($urandom_range(0, 5) != 0);
         reset = ($urandom_range(0, 299) == 0);
         step();
      end
      reset = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
